// File: rtl/envelope_follower.sv
// Envelope follower: full-wave rectifier feeding a shift-based attack/release one-pole filter,
// with a hysteretic note gate whose hold time is counted in envelope updates.
module envelope_follower #(
  parameter int unsigned                DATA_WIDTH   = 24,
  parameter logic [DATA_WIDTH-1:0]      GATE_ON      = 24'h080000,
  parameter logic [DATA_WIDTH-1:0]      GATE_OFF     = 24'h040000,
  parameter int unsigned                HOLD_SAMPLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            attack_shift_i,
  input  logic [4:0]            release_shift_i,
  output logic [DATA_WIDTH-1:0] envelope_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  gate_o
);

  localparam int unsigned CntW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] One = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StActive, StHold} state_e;

  logic                  adv;
  logic                  update;
  logic                  s1_v_q;
  logic [DATA_WIDTH-1:0] neg_sample;
  logic [DATA_WIDTH-1:0] rect_d, rect_q;
  logic [DATA_WIDTH-1:0] env_d, env_q;
  logic [DATA_WIDTH-1:0] diff_up, diff_dn;
  logic [DATA_WIDTH-1:0] step_up, step_dn;
  logic                  valid_q;
  state_e                state_d, state_q;
  logic [CntW-1:0]       cnt_d, cnt_q;

  // The whole pipeline advances together; a stalled output freezes every stage.
  assign adv     = ~valid_q | ready_i;
  assign ready_o = adv;
  assign update  = adv & s1_v_q;

  assign neg_sample = ~sample_i + One;

  always_comb begin
    rect_d = sample_i;
    if (sample_i[DATA_WIDTH-1]) begin
      // Negating the most-negative code wraps back to itself; clamp it to full scale.
      rect_d = neg_sample[DATA_WIDTH-1] ? MaxPos : neg_sample;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q <= 1'b0;
      rect_q <= '0;
    end else if (adv) begin
      s1_v_q <= valid_i;
      if (valid_i) begin
        rect_q <= rect_d;
      end
    end
  end

  always_comb begin
    diff_up = rect_q - env_q;
    diff_dn = env_q - rect_q;
    step_up = diff_up >> attack_shift_i;
    step_dn = diff_dn >> release_shift_i;
    if (step_up == '0) step_up = One;
    if (step_dn == '0) step_dn = One;
    env_d = env_q;
    // Steps never exceed the distance, so the envelope cannot overshoot rect.
    if (rect_q > env_q) begin
      env_d = env_q + step_up;
    end else if (rect_q < env_q) begin
      env_d = env_q - step_dn;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      env_q   <= '0;
      valid_q <= 1'b0;
    end else if (update) begin
      env_q   <= env_d;
      valid_q <= 1'b1;
    end else if (adv) begin
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (update) begin
      case (state_q)
        StIdle: begin
          if (env_d >= GATE_ON) state_d = StActive;
        end
        StActive: begin
          if (env_d < GATE_OFF) begin
            state_d = StHold;
            cnt_d   = HoldLast;
          end
        end
        StHold: begin
          if (env_d >= GATE_ON) begin
            state_d = StActive;
          end else if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign envelope_o = env_q;
  assign valid_o    = valid_q;
  assign gate_o     = (state_q != StIdle);

endmodule

// File: tb/tb_envelope_follower.sv
// Bench for envelope_follower: directed scenarios plus randomized streaming against an
// arithmetic model of rectify / attack-release / gate-with-hold.
module tb_envelope_follower;

  localparam int unsigned OnLvl  = 32'h080000;
  localparam int unsigned OffLvl = 32'h040000;
  localparam int          Hold   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sample;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  ash, rsh;
  logic [23:0] env;
  logic        valid_out;
  logic        ready_in;
  logic        gate;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_env;
  bit m_open;
  int m_hold;  // -1 when not in the hold window, else updates remaining
  int m_ash, m_rsh;

  typedef struct {
    int env;
    bit gate;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  envelope_follower #(
    .DATA_WIDTH  (24),
    .GATE_ON     (24'h080000),
    .GATE_OFF    (24'h040000),
    .HOLD_SAMPLES(Hold)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_i       (sample),
    .valid_i        (valid_in),
    .ready_o        (ready_out),
    .attack_shift_i (ash),
    .release_shift_i(rsh),
    .envelope_o     (env),
    .valid_o        (valid_out),
    .ready_i        (ready_in),
    .gate_o         (gate)
  );

  function automatic int rectify(logic [23:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32'h7FFFFF) v = 32'h7FFFFF;
    return v;
  endfunction

  function automatic void model_update(int rect);
    int d, step;
    d = rect - m_env;
    if (d > 0) begin
      step = d >> m_ash;
      if (step < 1) step = 1;
      m_env += step;
    end else if (d < 0) begin
      step = (-d) >> m_rsh;
      if (step < 1) step = 1;
      m_env -= step;
    end
    if (m_env >= OnLvl) begin
      m_open = 1'b1;
      m_hold = -1;
    end else if (m_open && m_hold < 0 && m_env < OffLvl) begin
      m_hold = Hold - 1;
    end else if (m_hold >= 0) begin
      if (m_hold == 0) begin
        m_open = 1'b0;
        m_hold = -1;
      end else begin
        m_hold--;
      end
    end
  endfunction

  function automatic logic [23:0] rand_sample();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 4))
      0:       return 24'h800000;
      1:       return 24'(r[7:0]);
      2:       return r[0] ? 24'($urandom_range(0, 32'h0C0000))
                           : 24'(-int'($urandom_range(0, 32'h0C0000)));
      default: return r[23:0];
    endcase
  endfunction

  task automatic set_shifts(input int a, input int r);
    ash   = 5'(a);
    rsh   = 5'(r);
    m_ash = a;
    m_rsh = r;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    sample   = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_env  = 0;
    m_open = 1'b0;
    m_hold = -1;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    #1;
    checks += 3;
    if (env !== 24'h0) begin failures++; $display("FAIL reset_env: got %h want 0", env); end
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got %b want 0", gate); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    m_env = 0; m_open = 1'b0; m_hold = -1; sb.delete();
  endtask

  task automatic test_latency();
    set_shifts(0, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL latency_early: got %b want 0", valid_out); end
      end
      if (i == 2) begin
        checks += 2;
        if (env !== 24'h123456) begin failures++; $display("FAIL latency_env: got %h want 123456", env); end
        if (valid_out !== 1'b1) begin failures++; $display("FAIL latency_valid: got %b want 1", valid_out); end
      end
      valid_in = (i == 0);
      sample   = 24'hEDCBAA;  // -0x123456
    end
  endtask

  task automatic test_attack();
    logic [23:0] want [3];
    want = '{24'h100000, 24'h1C0000, 24'h250000};
    set_shifts(2, 0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (env !== want[i-2]) begin
          failures++; $display("FAIL attack_step%0d: got %h want %h", i - 2, env, want[i-2]);
        end
      end
      valid_in = (i < 3);
      sample   = 24'h400000;
    end
  endtask

  task automatic test_saturate();
    logic [23:0] want [4];
    want = '{24'h7FFFFF, 24'h7FFFFE, 24'h7FFFFD, 24'h7FFFFC};
    set_shifts(0, 31);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (env !== want[i-2]) begin
          failures++; $display("FAIL saturate_%0d: got %h want %h", i - 2, env, want[i-2]);
        end
      end
      valid_in = (i < 4);
      sample   = (i == 0) ? 24'h800000 : 24'h000000;
    end
  endtask

  task automatic test_stall();
    logic [23:0] tab [10];
    int idx, k;
    for (int i = 0; i < 10; i++) tab[i] = 24'(i * 32'h10000 + 32'h1000);
    set_shifts(0, 0);
    apply_reset();
    idx = 0;
    k   = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      valid_in = (idx < 10);
      sample   = (idx < 10) ? tab[idx] : 24'h0;
      ready_in = !(cyc >= 3 && cyc <= 7);
      #1;
      if (cyc >= 3 && cyc <= 7) begin
        checks += 2;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL stall_ready c%0d: got %b want 0", cyc, ready_out); end
        if (env !== tab[k]) begin failures++; $display("FAIL stall_hold c%0d: got %h want %h", cyc, env, tab[k]); end
      end
      if (valid_out && ready_in) begin
        checks++;
        if (k >= 10) begin
          failures++; $display("FAIL stall_extra: got output %h want none", env);
        end else begin
          if (env !== tab[k]) begin failures++; $display("FAIL stall_out%0d: got %h want %h", k, env, tab[k]); end
          k++;
        end
      end
      if (valid_in && ready_out) idx++;
    end
    checks++;
    if (k != 10) begin failures++; $display("FAIL stall_count: got %0d want 10", k); end
  endtask

  task automatic test_gate();
    logic [23:0] gs [15];
    bit          ge [15];
    gs = '{24'h090000, 24'h030000, 24'h030000, 24'h030000, 24'h030000, 24'h030000,
           24'h090000, 24'h030000, 24'h030000, 24'h090000,
           24'h030000, 24'h030000, 24'h030000, 24'h030000, 24'h030000};
    ge = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    set_shifts(0, 0);
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks += 2;
        if (env !== gs[i-2]) begin failures++; $display("FAIL gate_env%0d: got %h want %h", i - 2, env, gs[i-2]); end
        if (gate !== ge[i-2]) begin failures++; $display("FAIL gate_flag%0d: got %b want %b", i - 2, gate, ge[i-2]); end
      end
      valid_in = (i < 15);
      sample   = (i < 15) ? gs[i] : 24'h0;
    end
  endtask

  task automatic test_reset_midstream();
    set_shifts(0, 0);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      sample   = 24'h090000;
    end
    @(negedge clk);
    checks += 2;
    if (valid_out !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %b want 1", valid_out); end
    if (gate !== 1'b1) begin failures++; $display("FAIL midrst_pre_gate: got %b want 1", gate); end
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    checks += 3;
    if (env !== 24'h0) begin failures++; $display("FAIL midrst_env: got %h want 0", env); end
    if (valid_out !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
    if (gate !== 1'b0) begin failures++; $display("FAIL midrst_gate: got %b want 0", gate); end
    @(negedge clk);
    rst_n = 1'b1;
    set_shifts(1, 0);
    @(negedge clk);
    valid_in = 1'b1;
    sample   = 24'h400000;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    checks += 3;
    if (env !== 24'h200000) begin failures++; $display("FAIL midrst_first: got %h want 200000", env); end
    if (valid_out !== 1'b1) begin failures++; $display("FAIL midrst_first_valid: got %b want 1", valid_out); end
    if (gate !== 1'b1) begin failures++; $display("FAIL midrst_first_gate: got %b want 1", gate); end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL midrst_stale: got %b want 0", valid_out); end
  endtask

  task automatic test_random();
    bit   holding;
    exp_t e;
    apply_reset();
    for (int ph = 0; ph < 4; ph++) begin
      set_shifts(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      if (ph == 0) set_shifts(0, 3);
      holding = 1'b0;
      for (int cyc = 0; cyc < 170; cyc++) begin
        @(negedge clk);
        if (cyc < 160) begin
          if (!holding) begin
            valid_in = ($urandom_range(0, 3) != 0);
            sample   = rand_sample();
          end
          ready_in = ($urandom_range(0, 3) != 0);
        end else begin
          valid_in = 1'b0;
          ready_in = 1'b1;
        end
        #1;
        if (valid_out && ready_in) begin
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL rand_extra p%0d: got %h want no output", ph, env);
          end else begin
            e = sb.pop_front();
            if (env !== 24'(e.env) || gate !== e.gate) begin
              failures++;
              $display("FAIL rand_out p%0d: got env=%h gate=%b want env=%h gate=%b",
                       ph, env, gate, 24'(e.env), e.gate);
            end
          end
        end
        if (valid_in && ready_out) begin
          model_update(rectify(sample));
          sb.push_back('{env: m_env, gate: m_open});
          holding = 1'b0;
        end else begin
          holding = valid_in;
        end
      end
      checks++;
      if (sb.size() != 0) begin
        failures++; $display("FAIL rand_drain p%0d: got %0d pending want 0", ph, sb.size());
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    sample   = '0;
    set_shifts(0, 0);
    test_reset();
    test_latency();
    test_attack();
    test_saturate();
    test_stall();
    test_gate();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
